// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word bit positions, default widths and
// the memory-unit state encoding.
package sap1_pkg;

    // Control-word bit positions as driven by the sequencer (LSB first).
    localparam int INCR_PC      = 0;
    localparam int EN_PC        = 1;
    localparam int MAR_LOAD_N   = 2;
    localparam int RAM_EN_N     = 3;
    localparam int IR_LOAD_N    = 4;
    localparam int IR_EN_N      = 5;
    localparam int A_LOAD_N     = 6;
    localparam int A_EN_N       = 7;
    localparam int ALU_SUB      = 8;
    localparam int ALU_EN       = 9;
    localparam int B_LOAD_N     = 10;
    localparam int OUT_REG_LOAD = 11;

    // Default datapath widths.
    localparam int SAP1_ADDR_W = 4;
    localparam int SAP1_DATA_W = 8;

    // Memory-unit operating states.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_PROG  = 2'd1,
        ST_RUN   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/sap1_ram16x8.sv
// Program/data RAM: one synchronous write port, one asynchronous read port.
module sap1_ram16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the selected word on the rising edge when enabled.
    // NOTE: the array has no reset branch on purpose; a reset would turn it into
    // a wide register bank instead of RAM. Contents are zeroed by the owning FSM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/sap1_mem_unit.sv
// SAP-1 memory stage: MAR, 16x8 RAM, post-reset RAM clear and program loader.
// Holds the CPU in reset until a program is loaded and run is requested.
module sap1_mem_unit
    import sap1_pkg::*;
#(
    parameter int ADDR_W = SAP1_ADDR_W,
    parameter int DATA_W = SAP1_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              run_i,
    input  logic              lm_n_i,
    input  logic              ce_n_i,
    input  logic [DATA_W-1:0] bus_i,
    input  logic              prog_valid_i,
    output logic              prog_ready_o,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    input  logic              prog_last_i,
    output logic              prog_done_o,
    output logic [ADDR_W-1:0] mar_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_drive_o,
    output logic              cpu_rstn_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mem_state_e        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_mar;
    logic              r_prog_ready;
    logic              r_prog_done;
    logic              r_cpu_rstn;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_xfer;

    // Only the low ADDR_W bus bits address the RAM; the rest are dropped.
    logic [DATA_W-ADDR_W-1:0] w_unused_bus_hi;
    assign w_unused_bus_hi = bus_i[DATA_W-1:ADDR_W];

    assign w_xfer = prog_valid_i && r_prog_ready;

    // Sequencing FSM with registered handshake, done flag, MAR and CPU reset.
    // NOTE: every register here uses <= so all of them sample the pre-edge
    // values; a blocking = would leak a new value into later statements.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_mar        <= '0;
            r_prog_ready <= 1'b0;
            r_prog_done  <= 1'b0;
            r_cpu_rstn   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cpu_rstn <= 1'b0;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        r_cnt <= '0;
                        if (run_i) begin
                            r_state      <= ST_RUN;
                            r_prog_ready <= 1'b0;
                        end else begin
                            r_state      <= ST_PROG;
                            r_prog_ready <= 1'b1;
                        end
                    end
                end
                ST_PROG: begin
                    r_cpu_rstn <= 1'b0;
                    if (w_xfer && prog_last_i) begin
                        r_prog_done <= 1'b1;
                    end
                    if (run_i) begin
                        r_state      <= ST_RUN;
                        r_prog_ready <= 1'b0;
                    end else begin
                        r_prog_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_i) begin
                        r_state      <= ST_PROG;
                        r_prog_ready <= 1'b1;
                        r_prog_done  <= 1'b0;
                        r_mar        <= '0;
                        r_cpu_rstn   <= 1'b0;
                    end else begin
                        r_prog_ready <= 1'b0;
                        r_cpu_rstn   <= 1'b1;
                        if (!lm_n_i) begin
                            r_mar <= bus_i[ADDR_W-1:0];
                        end
                    end
                end
                default: begin
                    r_state      <= ST_CLEAR;
                    r_cnt        <= '0;
                    r_mar        <= '0;
                    r_prog_ready <= 1'b0;
                    r_prog_done  <= 1'b0;
                    r_cpu_rstn   <= 1'b0;
                end
            endcase
        end
    end

    // Write-port mux: clear counter in CLEAR, program stream in PROG.
    // NOTE: defaults first so every path assigns every output and no latch forms.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
            end
            ST_PROG: begin
                w_we    = w_xfer;
                w_waddr = prog_addr_i;
                w_wdata = prog_data_i;
            end
            default: ;
        endcase
    end

    sap1_ram16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .raddr_i (r_mar),
        .rdata_o (w_rdata)
    );

    // Bus drive is combinational from CE so the sequencer's falling-edge
    // control change is seen within the same cycle.
    always_comb begin
        ram_drive_o = (r_state == ST_RUN) && !ce_n_i;
        ram_data_o  = ram_drive_o ? w_rdata : '0;
    end

    assign prog_ready_o = r_prog_ready;
    assign prog_done_o  = r_prog_done;
    assign mar_o        = r_mar;
    assign cpu_rstn_o   = r_cpu_rstn;

endmodule

// File: tb/tb_sap1_mem_unit.sv
// Self-checking bench for sap1_mem_unit using an expected-value queue.
module tb_sap1_mem_unit;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       run_i;
    logic       lm_n_i;
    logic       ce_n_i;
    logic [7:0] bus_i;
    logic       prog_valid_i;
    logic       prog_ready_o;
    logic [3:0] prog_addr_i;
    logic [7:0] prog_data_i;
    logic       prog_last_i;
    logic       prog_done_o;
    logic [3:0] mar_o;
    logic [7:0] ram_data_o;
    logic       ram_drive_o;
    logic       cpu_rstn_o;

    sap1_mem_unit dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .run_i        (run_i),
        .lm_n_i       (lm_n_i),
        .ce_n_i       (ce_n_i),
        .bus_i        (bus_i),
        .prog_valid_i (prog_valid_i),
        .prog_ready_o (prog_ready_o),
        .prog_addr_i  (prog_addr_i),
        .prog_data_i  (prog_data_i),
        .prog_last_i  (prog_last_i),
        .prog_done_o  (prog_done_o),
        .mar_o        (mar_o),
        .ram_data_o   (ram_data_o),
        .ram_drive_o  (ram_drive_o),
        .cpu_rstn_o   (cpu_rstn_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      tag;
        logic [3:0] addr;
        logic [7:0] data;
    } sb_item_t;

    sb_item_t   sb_q[$];
    logic [7:0] model [16];
    int         n_checks = 0;
    int         n_fails  = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; run_i = 1'b0; lm_n_i = 1'b0; ce_n_i = 1'b0; bus_i = 8'hA5;
        prog_valid_i = 1'b1; prog_addr_i = 4'h1; prog_data_i = 8'h77; prog_last_i = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({mar_o, prog_ready_o, prog_done_o, ram_drive_o, ram_data_o, cpu_rstn_o} !== 17'h0) begin
            n_fails++;
            $display("FAIL reset_outputs: got mar=%0h rdy=%0b done=%0b drv=%0b data=%0h cpu_rstn=%0b, want all 0",
                     mar_o, prog_ready_o, prog_done_o, ram_drive_o, ram_data_o, cpu_rstn_o);
        end
        lm_n_i = 1'b1; ce_n_i = 1'b1; prog_valid_i = 1'b0; prog_last_i = 1'b0;
    endtask

    // Releases reset and expects exactly 16 CLEAR edges, then PROG and zeroed RAM.
    task automatic test_clear(input string name);
        int cycles;
        cycles = 0;
        rstn_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (prog_ready_o === 1'b1) break;
        end
        n_checks++;
        if (cycles !== 16) begin
            n_fails++;
            $display("FAIL %s_length: got %0d cycles, want 16", name, cycles);
        end
        n_checks++;
        if (cpu_rstn_o !== 1'b0) begin
            n_fails++;
            $display("FAIL %s_cpu_rstn: got %0b, want 0", name, cpu_rstn_o);
        end
        for (int a = 0; a < 16; a++) begin
            model[a] = 8'h00;
            n_checks++;
            if (dut.u_ram.r_mem[a] !== 8'h00) begin
                n_fails++;
                $display("FAIL %s_mem[%0d]: got %0h, want 00", name, a, dut.u_ram.r_mem[a]);
            end
        end
    endtask

    task automatic test_prog_stream();
        logic [3:0] t_addr [4];
        logic [7:0] t_data [4];
        t_addr[0] = 4'd0; t_data[0] = 8'h09;
        t_addr[1] = 4'd1; t_data[1] = 8'h1A;
        t_addr[2] = 4'd2; t_data[2] = 8'hE0;
        t_addr[3] = 4'd3; t_data[3] = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                // Idle gap with junk on the data lines; nothing may be written.
                prog_valid_i = 1'b0; prog_addr_i = 4'd9; prog_data_i = 8'hFF; prog_last_i = 1'b1;
                repeat (2) tick();
                n_checks++;
                if (prog_ready_o !== 1'b1 || prog_done_o !== 1'b0) begin
                    n_fails++;
                    $display("FAIL prog_gap: got rdy=%0b done=%0b, want rdy=1 done=0", prog_ready_o, prog_done_o);
                end
            end
            prog_valid_i = 1'b1;
            prog_addr_i  = t_addr[i];
            prog_data_i  = t_data[i];
            prog_last_i  = (i == 3);
            run_i        = (i == 3);
            sb_q.push_back('{tag: "prog_word", addr: t_addr[i], data: t_data[i]});
            model[t_addr[i]] = t_data[i];
            tick();
            if (i < 3) begin
                n_checks++;
                if (prog_done_o !== 1'b0) begin
                    n_fails++;
                    $display("FAIL prog_done_early[%0d]: got %0b, want 0", i, prog_done_o);
                end
            end
        end
        prog_valid_i = 1'b0; prog_last_i = 1'b0;
        // First RUN cycle: transfer finished, CPU still held in reset.
        n_checks++;
        if ({prog_done_o, prog_ready_o, cpu_rstn_o, mar_o} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            n_fails++;
            $display("FAIL run_entry: got done=%0b rdy=%0b cpu_rstn=%0b mar=%0h, want 1 0 0 0",
                     prog_done_o, prog_ready_o, cpu_rstn_o, mar_o);
        end
        // Stream input must be ignored in RUN.
        prog_valid_i = 1'b1; prog_addr_i = 4'd4; prog_data_i = 8'h55;
        tick();
        prog_valid_i = 1'b0;
        n_checks++;
        if (cpu_rstn_o !== 1'b1 || mar_o !== 4'h0) begin
            n_fails++;
            $display("FAIL run_cpu_release: got cpu_rstn=%0b mar=%0h, want 1 0", cpu_rstn_o, mar_o);
        end
        while (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            n_checks++;
            if (dut.u_ram.r_mem[it.addr] !== it.data) begin
                n_fails++;
                $display("FAIL %s[%0d]: got %0h, want %0h", it.tag, it.addr, dut.u_ram.r_mem[it.addr], it.data);
            end
        end
        for (int a = 4; a < 16; a++) begin
            n_checks++;
            if (dut.u_ram.r_mem[a] !== model[a]) begin
                n_fails++;
                $display("FAIL prog_untouched[%0d]: got %0h, want %0h", a, dut.u_ram.r_mem[a], model[a]);
            end
        end
    endtask

    task automatic test_run_mar();
        sb_item_t it;
        bus_i = 8'hF2; lm_n_i = 1'b0;
        tick();
        lm_n_i = 1'b1; bus_i = 8'h00;
        n_checks++;
        if (mar_o !== 4'h2) begin
            n_fails++;
            $display("FAIL mar_load: got %0h, want 2", mar_o);
        end
        ce_n_i = 1'b0;
        sb_q.push_back('{tag: "ram_read", addr: 4'h2, data: model[2]});
        #1;
        n_checks++;
        if (ram_drive_o !== 1'b1) begin
            n_fails++;
            $display("FAIL ram_drive_on: got %0b, want 1", ram_drive_o);
        end
        it = sb_q.pop_front();
        n_checks++;
        if (ram_data_o !== it.data) begin
            n_fails++;
            $display("FAIL %s[%0d]: got %0h, want %0h", it.tag, it.addr, ram_data_o, it.data);
        end
        ce_n_i = 1'b1;
        #1;
        n_checks++;
        if (ram_drive_o !== 1'b0 || ram_data_o !== 8'h00) begin
            n_fails++;
            $display("FAIL ram_drive_off: got drv=%0b data=%0h, want 0 00", ram_drive_o, ram_data_o);
        end
    endtask

    task automatic test_back_to_back();
        sb_item_t it;
        bus_i = 8'h01; lm_n_i = 1'b0;
        tick();
        lm_n_i = 1'b0; ce_n_i = 1'b0; bus_i = 8'h03;
        sb_q.push_back('{tag: "b2b_old_mar", addr: 4'h1, data: model[1]});
        #1;
        it = sb_q.pop_front();
        n_checks++;
        if (ram_drive_o !== 1'b1 || ram_data_o !== it.data) begin
            n_fails++;
            $display("FAIL %s: got drv=%0b data=%0h, want 1 %0h", it.tag, ram_drive_o, ram_data_o, it.data);
        end
        sb_q.push_back('{tag: "b2b_new_mar", addr: 4'h3, data: model[3]});
        tick();
        n_checks++;
        if (mar_o !== 4'h3) begin
            n_fails++;
            $display("FAIL b2b_mar: got %0h, want 3", mar_o);
        end
        it = sb_q.pop_front();
        n_checks++;
        if (ram_data_o !== it.data) begin
            n_fails++;
            $display("FAIL %s: got %0h, want %0h", it.tag, ram_data_o, it.data);
        end
        lm_n_i = 1'b1; ce_n_i = 1'b1; bus_i = 8'h00;
    endtask

    task automatic test_prog_return();
        ce_n_i = 1'b0;
        run_i  = 1'b0;
        tick();
        n_checks++;
        if ({cpu_rstn_o, mar_o, prog_done_o, prog_ready_o, ram_drive_o, ram_data_o} !==
            {1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fails++;
            $display("FAIL prog_return: got cpu_rstn=%0b mar=%0h done=%0b rdy=%0b drv=%0b data=%0h, want 0 0 0 1 0 00",
                     cpu_rstn_o, mar_o, prog_done_o, prog_ready_o, ram_drive_o, ram_data_o);
        end
        ce_n_i = 1'b1;
        for (int a = 0; a < 16; a++) begin
            n_checks++;
            if (dut.u_ram.r_mem[a] !== model[a]) begin
                n_fails++;
                $display("FAIL retain[%0d]: got %0h, want %0h", a, dut.u_ram.r_mem[a], model[a]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({mar_o, prog_ready_o, prog_done_o, ram_drive_o, ram_data_o, cpu_rstn_o} !== 17'h0) begin
            n_fails++;
            $display("FAIL reset_async: got mar=%0h rdy=%0b done=%0b drv=%0b data=%0h cpu_rstn=%0b, want all 0",
                     mar_o, prog_ready_o, prog_done_o, ram_drive_o, ram_data_o, cpu_rstn_o);
        end
        tick();
        rstn_i = 1'b1;
        repeat (7) tick();
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({mar_o, prog_ready_o, prog_done_o, ram_drive_o, ram_data_o, cpu_rstn_o} !== 17'h0) begin
            n_fails++;
            $display("FAIL reset_mid_clear: got mar=%0h rdy=%0b done=%0b drv=%0b data=%0h cpu_rstn=%0b, want all 0",
                     mar_o, prog_ready_o, prog_done_o, ram_drive_o, ram_data_o, cpu_rstn_o);
        end
        tick();
        test_clear("clear_restart");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear("clear_initial");
        test_prog_stream();
        test_run_mar();
        test_back_to_back();
        test_prog_return();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sap1_mem_unit.md
Name: sap1_mem_unit

Overview:
SAP-1 memory stage: MAR (4-bit) plus 16x8 program/data RAM, directly downstream of the sequencer's control word. Consumes the active-low MAR-load and RAM-enable control bits and the 8-bit W bus. Sources RAM data back onto the bus. Owns program loading: it clears RAM after reset, accepts a valid/ready program stream, and holds the CPU in reset until loading is finished and run is requested.

Parameters:
ADDR_W, 4, MAR/RAM address width
DATA_W, 8, bus and RAM word width
DEPTH, 16, RAM words (must equal 2**ADDR_W)

Ports:
clk_i  in  1  clock; all state updates on rising edge (the sequencer changes the control word on the falling edge)
rstn_i  in  1  reset, asynchronous, active-low
run_i  in  1  1 = run requested, 0 = program mode requested
lm_n_i  in  1  MAR load, active-low (control word bit 2)
ce_n_i  in  1  RAM output enable, active-low (control word bit 3)
bus_i  in  DATA_W  W bus value
prog_valid_i  in  1  program word valid
prog_ready_o  out  1  program word accepted this cycle if valid
prog_addr_i  in  ADDR_W  program word address
prog_data_i  in  DATA_W  program word data
prog_last_i  in  1  marks final word of a program
prog_done_o  out  1  sticky: last word received
mar_o  out  ADDR_W  current MAR contents
ram_data_o  out  DATA_W  RAM word at MAR; forced to 0 when ram_drive_o=0
ram_drive_o  out  1  RAM owns the bus this cycle
cpu_rstn_o  out  1  active-low reset to PC/controller/registers

Behaviour:
- Reset values:
  - state=CLEAR, clear counter=0, mar_o=0.
  - prog_ready_o=0, prog_done_o=0, ram_drive_o=0, ram_data_o=0, cpu_rstn_o=0.
  - RAM contents are not reset directly; the CLEAR state zeroes them.
- State CLEAR:
  - Writes 0 to mem[cnt] each cycle, cnt 0..DEPTH-1, so it lasts exactly DEPTH cycles.
  - After writing address DEPTH-1: go to RUN if run_i=1, else PROG.
  - No handshake or MAR activity; cpu_rstn_o=0.
- State PROG:
  - prog_ready_o=1 (registered; high from the first PROG cycle).
  - On valid&ready: mem[prog_addr_i] <= prog_data_i. If prog_last_i=1, set prog_done_o.
  - Repeated addresses: last write wins.
  - cpu_rstn_o=0, lm_n_i and ce_n_i ignored, MAR held.
  - Leave to RUN on any cycle with run_i=1. A transfer in that same cycle still completes. prog_ready_o=0 from the next cycle.
- State RUN:
  - prog_ready_o=0; prog_valid_i ignored.
  - cpu_rstn_o goes 1 one cycle after entering RUN (registered), so the CPU starts with MAR=0.
  - If lm_n_i=0 at a rising edge: mar_o <= bus_i[ADDR_W-1:0]. Upper bus bits are discarded.
  - ram_drive_o = !ce_n_i (combinational, RUN only).
  - ram_data_o = mem[mar_o] when driving (asynchronous read), else 0.
  - lm_n_i and ce_n_i both low in one cycle: ram_data_o shows the old MAR address; MAR updates at the edge. No bypass.
  - run_i=0 → PROG next cycle:
    - cpu_rstn_o=0 and ram_drive_o=0 immediately with the state change.
    - mar_o reset to 0 and prog_done_o cleared on PROG entry.
    - RAM contents retained.
- rstn_i asserted mid-operation (including mid-CLEAR or mid-transfer): immediate return to reset values. CLEAR restarts from address 0 on release.
- No other transitions; illegal state encodings recover to CLEAR.

Decomposition:
- Shared package sap1_pkg:
  - control-word bit indices (INCR_PC..OUT_REG_LOAD), already used by the controller.
  - ADDR_W/DATA_W defaults.
  - mem-unit state encoding (CLEAR, PROG, RUN).
- One sub-module: sap1_ram16x8.
  - Single write port (addr, data, we) and asynchronous read port.
  - Write-port mux (clear counter vs program stream) stays in sap1_mem_unit.

Test Plan:
- Reset release, run_i=0 → CLEAR lasts exactly 16 cycles; then prog_ready_o=1, cpu_rstn_o=0. Backdoor read: all 16 words = 8'h00.
- PROG stream: words (0,8'h09), (1,8'h1A), (2,8'hE0), (3,8'hF0, last); prog_valid_i dropped for 2 cycles between words 1 and 2 → exactly 4 writes, prog_done_o=1 after word 3, other words remain 0.
- Raise run_i in the same cycle as the last transfer → word stored; RUN next cycle; cpu_rstn_o=1 one cycle later; mar_o=0.
- RUN: bus_i=8'hF2, lm_n_i=0 for one edge → mar_o=2. Then ce_n_i=0 → ram_drive_o=1, ram_data_o=8'hE0. With ce_n_i=1 → ram_data_o=0.
- RUN: lm_n_i=0, ce_n_i=0, bus_i=8'h03, MAR=1 → ram_data_o=8'h1A that cycle, mar_o=3 next cycle.
- Drop run_i → PROG, cpu_rstn_o=0, mar_o=0, prog_done_o=0, RAM unchanged. Then pulse rstn_i low mid-CLEAR (cycle 7) → outputs at reset values; CLEAR restarts and lasts 16 cycles.
